cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle instruction sequencer for the 8-bit RISC CPU.
- Owns the program counter and instruction register.
- Steps each instruction through fetch, decode, operand access and execute.
- Issues the ALU opcode and accumulator-load strobe.
- Arbitrates the single program/data memory port between the CPU and an external program loader.
- Sits between the memory, the ALU/accumulator datapath and the loader interface.

## Interface
- `ADDR_W`, default 5: memory address width; equals the instruction operand field width.
- `DATA_W`, default 8: instruction/data width. Fixed at 8; opcode is `[7:5]`, operand is `[4:0]`.
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-low. Sampled on the rising edge of `clock`.
- `load_req` in 1: external loader requests the memory port.
- `load_gnt` out 1: memory port granted to the loader.
- `mem_rdata` in 8: memory read data.
- `mem_ready` in 1: completes the current memory access this cycle.
- `mem_addr` out ADDR_W: memory address.
- `mem_rd` out 1: read request.
- `mem_wr` out 1: write request. Write data comes from the accumulator outside this block.
- `acc_zero` in 1: accumulator equals zero.
- `acc_ld` out 1: one-cycle accumulator load strobe.
- `alu_op` out 3: opcode presented to the ALU.
- `pc` out ADDR_W: current program counter.
- `ir` out 8: current instruction register.
- `halted` out 1: sequencer is in HALT.

## Operation
- Opcodes:
  - 000 HLT
  - 001 SKZ
  - 010 ADD
  - 011 AND
  - 100 XOR
  - 101 LDA
  - 110 STO
  - 111 JMP
- States: FETCH, DECODE, OP_RD, EXEC, OP_WR, HALT, LOAD.
- FETCH:
  - Outputs: `mem_addr=pc`, `mem_rd=1`.
  - Holds until `mem_ready`. On the ready cycle: `ir<=mem_rdata`, `pc<=pc+1` (modulo 2^ADDR_W, 31 wraps to 0), go to DECODE.
- DECODE, by `ir[7:5]`:
  - HLT: go to HALT.
  - JMP: `pc<=ir[4:0]`, go to FETCH.
  - SKZ: if `acc_zero`, `pc<=pc+1` (wraps). Go to FETCH.
  - ADD/AND/XOR/LDA: go to OP_RD.
  - STO: go to OP_WR.
- OP_RD:
  - Outputs: `mem_addr=ir[4:0]`, `mem_rd=1`.
  - Holds until `mem_ready`, then goes to EXEC.
- EXEC: `acc_ld=1` for exactly this cycle, then go to FETCH.
- OP_WR:
  - Outputs: `mem_addr=ir[4:0]`, `mem_wr=1`.
  - Holds until `mem_ready`, then goes to FETCH. `acc_ld` stays 0.
- `alu_op` is registered. It loads `ir[7:5]` on the DECODE cycle and holds until the next DECODE.
- Loader arbitration:
  - `load_req` is honoured only on FETCH entry (instruction boundary) or while in HALT. Never mid-instruction.
  - If `load_req=1` when FETCH would be entered, the sequencer enters LOAD instead.
  - LOAD: `load_gnt=1`; `mem_rd`, `mem_wr`, `acc_ld` = 0; `mem_addr` = 0.
  - On the first cycle with `load_req=0`: `pc<=0`, go to FETCH.
- HALT:
  - `halted=1`, no memory access.
  - Exits only via LOAD or reset.
- Reset (`reset=0` at a clock edge, any state, including mid-access):
  - State goes to FETCH. The abandoned access is not completed.
  - `pc=0`, `ir=0`, `alu_op=000`.
  - `acc_ld`, `load_gnt`, `halted` = 0.
  - FETCH state drives `mem_rd=1`, `mem_addr=0` from the first cycle after reset.

## Timing
- Control outputs `mem_addr`, `mem_rd`, `mem_wr`, `acc_ld`, `load_gnt`, `halted` are Moore outputs decoded from state only. None depend combinationally on `mem_ready`, `load_req` or `acc_zero`.
- `mem_ready` may be high in the first cycle of a request, giving zero wait states. Each low cycle adds one.
- Zero-wait cycle counts:
  - ADD/AND/XOR/LDA: 4 (FETCH, DECODE, OP_RD, EXEC).
  - STO: 3.
  - JMP/SKZ: 2.
  - HLT: 2, then HALT.
- `acc_ld` asserts 1 cycle after the OP_RD ready cycle, while `mem_rdata` is still held stable by memory.
- `load_gnt` rises 1 cycle after honoured `load_req` and falls 1 cycle after `load_req` drops.

## Structure
- Shared package `cpu_pkg`:
  - Opcode constants `OP_HLT` … `OP_JMP`.
  - State enum `seq_state_t`.
  - `ADDR_W`/`DATA_W` defaults.
- Natural sub-module `cpu_pc`: program counter with synchronous clear, load, and increment-with-wrap.
- Everything else (FSM, IR, `alu_op` register) lives in `cpu_sequencer`.

## Test plan
- Reset: hold `reset=0` for 3 cycles, release → `pc=0`, FETCH with `mem_rd=1` and `mem_addr=0`.
- Program `LDA 10; ADD 11; STO 12; HLT` with zero-wait memory:
  - `acc_ld` pulses in cycles 4 and 8.
  - `mem_wr` asserts with `mem_addr=12` in cycle 11.
  - `halted=1` from cycle 14.
- Wait states: `mem_ready` low for 2 cycles on every access → ADD takes 8 cycles; `ir`/`alu_op` stable throughout.
- Branching:
  - `JMP 31` then the instruction at 31 → `pc` wraps to 0 after that fetch.
  - SKZ with `acc_zero=1` skips one instruction; SKZ with `acc_zero=0` does not.
- Loader:
  - `load_req` raised during OP_RD → `load_gnt` only after EXEC completes.
  - `load_req` released → `pc=0` and fetch restarts.
  - From HALT, a loader request is honoured within 1 cycle.
- Reset mid-OP_WR with `mem_ready` low → `mem_wr` drops after the reset edge; no `acc_ld`; `pc=0`.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit RISC CPU.
// Covers opcode encodings, sequencer states and default bus widths.
package cpu_pkg;

  localparam int CPU_ADDR_W = 5;
  localparam int CPU_DATA_W = 8;

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_OP_RD  = 3'd2,
    S_EXEC   = 3'd3,
    S_OP_WR  = 3'd4,
    S_HALT   = 3'd5,
    S_LOAD   = 3'd6
  } seq_state_t;

  function automatic logic [2:0] opcode_of(input logic [7:0] instr);
    return instr[7:5];
  endfunction

endpackage

// File: rtl/cpu_pc.sv
// Program counter: synchronous clear, parallel load and increment.
// The increment wraps modulo 2^ADDR_W.
module cpu_pc
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_clr,
  input  logic              i_ld,
  input  logic [ADDR_W-1:0] i_ld_val,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_pc
);

  logic [ADDR_W-1:0] r_pc;

  // Reset and clear beat load, load beats increment.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_pc <= {ADDR_W{1'b0}};
    end else if (i_clr) begin
      r_pc <= {ADDR_W{1'b0}};
    end else if (i_ld) begin
      r_pc <= i_ld_val;
    end else if (i_inc) begin
      r_pc <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      r_pc <= r_pc;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer for the 8-bit RISC CPU.
// Holds IR, alu_op and the control FSM; shares the memory port with the loader.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_req,
  output logic              load_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic              acc_zero,
  output logic              acc_ld,
  output logic [2:0]        alu_op,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ir,
  output logic              halted
);

  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  seq_state_t        w_boundary;
  logic [DATA_W-1:0] r_ir;
  logic [2:0]        r_alu_op;
  logic [ADDR_W-1:0] w_pc;
  logic [ADDR_W-1:0] w_operand;
  logic [2:0]        w_opcode;
  logic              w_pc_clr;
  logic              w_pc_ld;
  logic              w_pc_inc;
  logic              w_ir_ld;
  logic              w_alu_op_ld;

  assign w_opcode  = opcode_of(r_ir);
  assign w_operand = r_ir[ADDR_W-1:0];

  // A pending loader request claims the port at every instruction boundary.
  assign w_boundary = load_req ? S_LOAD : S_FETCH;

  cpu_pc #(
    .ADDR_W(ADDR_W)
  ) u_pc (
    .i_clock  (clock),
    .i_reset_n(reset),
    .i_clr    (w_pc_clr),
    .i_ld     (w_pc_ld),
    .i_ld_val (w_operand),
    .i_inc    (w_pc_inc),
    .o_pc     (w_pc)
  );

  // State register; reset abandons any access in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Instruction register and the ALU opcode latched at decode.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_ir     <= {DATA_W{1'b0}};
      r_alu_op <= OP_HLT;
    end else begin
      if (w_ir_ld) begin
        r_ir <= mem_rdata;
      end else begin
        r_ir <= r_ir;
      end
      if (w_alu_op_ld) begin
        r_alu_op <= w_opcode;
      end else begin
        r_alu_op <= r_alu_op;
      end
    end
  end

  // Next-state and datapath-update decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_clr    = 1'b0;
    w_pc_ld     = 1'b0;
    w_pc_inc    = 1'b0;
    w_ir_ld     = 1'b0;
    w_alu_op_ld = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready) begin
          w_ir_ld     = 1'b1;
          w_pc_inc    = 1'b1;
          w_state_nxt = S_DECODE;
        end else begin
          w_state_nxt = S_FETCH;
        end
      end
      S_DECODE: begin
        w_alu_op_ld = 1'b1;
        case (w_opcode)
          OP_HLT: w_state_nxt = S_HALT;
          OP_JMP: begin
            w_pc_ld     = 1'b1;
            w_state_nxt = w_boundary;
          end
          OP_SKZ: begin
            if (acc_zero) begin
              w_pc_inc = 1'b1;
            end else begin
              w_pc_inc = 1'b0;
            end
            w_state_nxt = w_boundary;
          end
          OP_STO: w_state_nxt = S_OP_WR;
          OP_ADD, OP_AND, OP_XOR, OP_LDA: w_state_nxt = S_OP_RD;
          default: w_state_nxt = S_HALT;
        endcase
      end
      S_OP_RD: begin
        if (mem_ready) begin
          w_state_nxt = S_EXEC;
        end else begin
          w_state_nxt = S_OP_RD;
        end
      end
      S_EXEC: w_state_nxt = w_boundary;
      S_OP_WR: begin
        if (mem_ready) begin
          w_state_nxt = w_boundary;
        end else begin
          w_state_nxt = S_OP_WR;
        end
      end
      S_HALT: begin
        if (load_req) begin
          w_state_nxt = S_LOAD;
        end else begin
          w_state_nxt = S_HALT;
        end
      end
      S_LOAD: begin
        if (!load_req) begin
          w_pc_clr    = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          w_state_nxt = S_LOAD;
        end
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Moore control outputs, decoded from the state register only.
  always_comb begin
    mem_addr = {ADDR_W{1'b0}};
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    acc_ld   = 1'b0;
    load_gnt = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_addr = w_pc;
        mem_rd   = 1'b1;
      end
      S_OP_RD: begin
        mem_addr = w_operand;
        mem_rd   = 1'b1;
      end
      S_EXEC:  acc_ld = 1'b1;
      S_OP_WR: begin
        mem_addr = w_operand;
        mem_wr   = 1'b1;
      end
      S_HALT:  halted   = 1'b1;
      S_LOAD:  load_gnt = 1'b1;
      default: mem_rd   = 1'b0;
    endcase
  end

  assign pc     = w_pc;
  assign ir     = r_ir;
  assign alu_op = r_alu_op;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs push expected bus events,
// a monitor pops and compares them as the sequencer produces them.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam logic [3:0] K_RD   = 4'd1;
  localparam logic [3:0] K_WR   = 4'd2;
  localparam logic [3:0] K_ACC  = 4'd3;
  localparam logic [3:0] K_HALT = 4'd4;
  localparam logic [3:0] K_GNT  = 4'd5;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       load_req = 1'b0;
  logic       load_gnt;
  logic [7:0] mem_rdata;
  logic       mem_ready = 1'b0;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic       mem_wr;
  logic       acc_zero = 1'b0;
  logic       acc_ld;
  logic [2:0] alu_op;
  logic [4:0] pc;
  logic [7:0] ir;
  logic       halted;

  logic [7:0]  mem [0:31];
  logic [31:0] exp_q [$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        rst_q = 1'b0;
  int          wait_n = 0;
  int          wcnt = 0;
  logic        halted_q = 1'b0;
  logic        gnt_q = 1'b0;
  logic        stable;

  cpu_sequencer dut (
    .clock    (clock),
    .reset    (reset),
    .load_req (load_req),
    .load_gnt (load_gnt),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .acc_zero (acc_zero),
    .acc_ld   (acc_ld),
    .alu_op   (alu_op),
    .pc       (pc),
    .ir       (ir),
    .halted   (halted)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem[mem_addr];

  // Cycle 1 is the first cycle after the last reset edge.
  always @(posedge clock) begin
    cyc   <= reset ? cyc + 1 : 1;
    rst_q <= reset;
  end

  function automatic logic [31:0] mk(input logic [3:0] k, input int c, input logic [4:0] a,
                                     input logic [7:0] d, input logic [2:0] o);
    logic [31:0] cv;
    cv = c;
    return {k, cv[7:0], a, d, o, 4'h0};
  endfunction

  task automatic push_exp(input logic [3:0] k, input int c, input logic [4:0] a,
                          input logic [7:0] d, input logic [2:0] o);
    exp_q.push_back(mk(k, c, a, d, o));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, expv);
    end
  endtask

  task automatic got(input logic [31:0] ev);
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_event got=%h want=none", ev);
    end else begin
      e = exp_q.pop_front();
      if (ev !== e) begin
        bad++;
        $display("FAIL event got=%h want=%h", ev, e);
      end
    end
  endtask

  // Memory: ready after wait_n low cycles of each access.
  initial begin
    forever begin
      @(posedge clock);
      #3;
      if (!rst_q || mem_ready) wcnt = 0;
      if ((mem_rd || mem_wr) && wcnt >= wait_n) begin
        mem_ready = 1'b1;
      end else begin
        mem_ready = 1'b0;
        if (mem_rd || mem_wr) wcnt++;
      end
    end
  end

  // Monitor: turns observed bus activity into events for the scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      if (reset === 1'b1) begin
        if (mem_rd && mem_ready) got(mk(K_RD, cyc, mem_addr, mem_rdata, 3'd0));
        if (mem_wr && mem_ready) got(mk(K_WR, cyc, mem_addr, ir, alu_op));
        if (acc_ld) got(mk(K_ACC, cyc, 5'd0, ir, alu_op));
        if (halted && !halted_q) got(mk(K_HALT, cyc, pc, 8'd0, 3'd0));
        if (load_gnt && !gnt_q) got(mk(K_GNT, cyc, pc, 8'd0, 3'd0));
      end
      halted_q = halted;
      gnt_q    = load_gnt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_mem();
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  task automatic at_cyc(input int n);
    int g;
    g = 0;
    while (cyc < n && g < 500) begin
      @(posedge clock);
      #2;
      g++;
    end
    chk("sync", 32'(cyc), 32'(n));
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (exp_q.size() != 0 && g < 300) begin
      @(posedge clock);
      g++;
    end
    repeat (4) @(posedge clock);
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    // Reset: all-zero memory fetches HLT at 0.
    clear_mem();
    wait_n = 0;
    push_exp(K_RD, 1, 5'd0, 8'h00, 3'd0);
    push_exp(K_HALT, 3, 5'd1, 8'h00, 3'd0);
    do_reset();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_fetch", 32'({mem_rd, mem_wr, mem_addr}), 32'({1'b1, 1'b0, 5'd0}));
    chk("rst_regs", 32'({ir, alu_op, acc_ld, load_gnt, halted}), 32'd0);
    drain();

    // LDA 10; ADD 11; STO 12; HLT, then a reload from HALT.
    clear_mem();
    mem[0] = 8'hAA; mem[1] = 8'h4B; mem[2] = 8'hCC; mem[3] = 8'h00;
    mem[10] = 8'h05; mem[11] = 8'h03;
    push_exp(K_RD, 1, 5'd0, 8'hAA, 3'd0);
    push_exp(K_RD, 3, 5'd10, 8'h05, 3'd0);
    push_exp(K_ACC, 4, 5'd0, 8'hAA, OP_LDA);
    push_exp(K_RD, 5, 5'd1, 8'h4B, 3'd0);
    push_exp(K_RD, 7, 5'd11, 8'h03, 3'd0);
    push_exp(K_ACC, 8, 5'd0, 8'h4B, OP_ADD);
    push_exp(K_RD, 9, 5'd2, 8'hCC, 3'd0);
    push_exp(K_WR, 11, 5'd12, 8'hCC, OP_STO);
    push_exp(K_RD, 12, 5'd3, 8'h00, 3'd0);
    push_exp(K_HALT, 14, 5'd4, 8'h00, 3'd0);
    push_exp(K_GNT, 17, 5'd4, 8'h00, 3'd0);
    push_exp(K_RD, 20, 5'd0, 8'h00, 3'd0);
    push_exp(K_HALT, 22, 5'd1, 8'h00, 3'd0);
    do_reset();
    at_cyc(15);
    chk("halt_state", 32'({halted, mem_rd, mem_wr, pc}), 32'({1'b1, 1'b0, 1'b0, 5'd4}));
    at_cyc(16);
    load_req = 1'b1;
    at_cyc(18);
    chk("halt_load_outs", 32'({load_gnt, mem_rd, halted, mem_addr}), 32'({1'b1, 1'b0, 1'b0, 5'd0}));
    mem[0] = 8'h00;
    at_cyc(19);
    load_req = 1'b0;
    drain();

    // Two wait states on every access: ADD spans 8 cycles.
    clear_mem();
    wait_n = 2;
    mem[0] = 8'h4B; mem[11] = 8'h03;
    push_exp(K_RD, 3, 5'd0, 8'h4B, 3'd0);
    push_exp(K_RD, 7, 5'd11, 8'h03, 3'd0);
    push_exp(K_ACC, 8, 5'd0, 8'h4B, OP_ADD);
    push_exp(K_RD, 11, 5'd1, 8'h00, 3'd0);
    push_exp(K_HALT, 13, 5'd2, 8'h00, 3'd0);
    do_reset();
    at_cyc(5);
    stable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (ir !== 8'h4B || alu_op !== OP_ADD) stable = 1'b0;
      @(posedge clock);
      #2;
    end
    chk("wait_ir_stable", 32'(stable), 32'd1);
    drain();
    wait_n = 0;

    // SKZ taken, JMP 31, fetch wrap to 0, SKZ not taken, HLT.
    clear_mem();
    mem[0] = 8'h20; mem[1] = 8'h00; mem[2] = 8'hFF; mem[31] = 8'h20;
    acc_zero = 1'b1;
    push_exp(K_RD, 1, 5'd0, 8'h20, 3'd0);
    push_exp(K_RD, 3, 5'd2, 8'hFF, 3'd0);
    push_exp(K_RD, 5, 5'd31, 8'h20, 3'd0);
    push_exp(K_RD, 7, 5'd0, 8'h20, 3'd0);
    push_exp(K_RD, 9, 5'd1, 8'h00, 3'd0);
    push_exp(K_HALT, 11, 5'd2, 8'h00, 3'd0);
    do_reset();
    at_cyc(3);
    chk("skz_taken_pc", 32'(pc), 32'd2);
    acc_zero = 1'b0;
    at_cyc(6);
    chk("wrap_pc", 32'(pc), 32'd0);
    at_cyc(9);
    chk("skz_not_taken", 32'({mem_addr, pc}), 32'({5'd1, 5'd1}));
    drain();

    // Loader request during OP_RD waits for the instruction to finish.
    clear_mem();
    mem[0] = 8'hAA; mem[10] = 8'h07;
    push_exp(K_RD, 1, 5'd0, 8'hAA, 3'd0);
    push_exp(K_RD, 3, 5'd10, 8'h07, 3'd0);
    push_exp(K_ACC, 4, 5'd0, 8'hAA, OP_LDA);
    push_exp(K_GNT, 5, 5'd1, 8'h00, 3'd0);
    push_exp(K_RD, 8, 5'd0, 8'h00, 3'd0);
    push_exp(K_HALT, 10, 5'd1, 8'h00, 3'd0);
    do_reset();
    at_cyc(3);
    load_req = 1'b1;
    at_cyc(4);
    chk("no_gnt_mid_instr", 32'({load_gnt, acc_ld}), 32'd1);
    at_cyc(6);
    chk("load_outs", 32'({load_gnt, mem_rd, mem_wr, acc_ld, mem_addr}),
        32'({1'b1, 1'b0, 1'b0, 1'b0, 5'd0}));
    mem[0] = 8'h00;
    at_cyc(7);
    load_req = 1'b0;
    at_cyc(8);
    chk("load_exit_fetch", 32'({pc, mem_rd, load_gnt}), 32'({5'd0, 1'b1, 1'b0}));
    drain();

    // Reset while OP_WR is stalled.
    clear_mem();
    mem[0] = 8'hCC;
    push_exp(K_RD, 1, 5'd0, 8'hCC, 3'd0);
    do_reset();
    at_cyc(2);
    wait_n = 100;
    at_cyc(4);
    chk("wr_stalled", 32'({mem_wr, mem_addr}), 32'({1'b1, 5'd12}));
    reset = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    wait_n = 0;
    chk("rst_mid_wr_bus", 32'({mem_wr, mem_rd, mem_addr, acc_ld}), 32'({1'b0, 1'b1, 5'd0, 1'b0}));
    chk("rst_mid_wr_regs", 32'({pc, ir, alu_op}), 32'd0);
    push_exp(K_RD, 1, 5'd0, 8'hCC, 3'd0);
    push_exp(K_WR, 3, 5'd12, 8'hCC, OP_STO);
    push_exp(K_RD, 4, 5'd1, 8'h00, 3'd0);
    push_exp(K_HALT, 6, 5'd2, 8'h00, 3'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
